axis_rr_arbiter: RTL and testbench



---
 rtl/axis_rr_arbiter_pkg.sv | 17 +
 rtl/rr_priority_select.sv | 35 +++
 rtl/axis_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_axis_rr_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/axis_rr_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream round-robin arbiter.
//   arb_state_e : arbiter FSM encoding (IDLE = 0, BUSY = 1)
//   rr_dist     : rotating-priority distance of a port from the last grant
package axis_rr_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  // Search position of port j when the search starts at (last+1) mod ports.
  // 0 means highest priority, ports-1 means lowest (the last granted port).
  function automatic int rr_dist(int j, int last, int ports);
    return (j + ports - 1 - last) % ports;
  endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational rotating-priority search.
//   req   : request vector, one bit per port
//   last  : previously granted port; the search starts at last+1 and wraps
//           from PORTS-1 to 0, so indices >= PORTS are never produced
//   found : at least one request present
//   sel   : first requesting port in rotating order (0 when !found)
module rr_priority_select
  import axis_rr_arbiter_pkg::*;
#(
  parameter int PORTS     = 4,
  parameter int PORT_BITS = 2
) (
  input  logic [PORTS-1:0]     req,
  input  logic [PORT_BITS-1:0] last,
  output logic                 found,
  output logic [PORT_BITS-1:0] sel
);

  int best;

  // Keep the requester with the smallest rotating distance.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    best  = PORTS;
    for (int j = 0; j < PORTS; j++) begin
      if (req[j] && (rr_dist(j, int'(last), PORTS) < best)) begin
        best  = rr_dist(j, int'(last), PORTS);
        found = 1'b1;
        sel   = PORT_BITS'(j);
      end
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// Packet-aware round-robin arbiter: PORTS AXI-Stream sources share one
// registered AXI-Stream output. A grant is held for a whole packet (until a
// tlast beat), so packets are never interleaved.
//   clock, resetn            : clock, async active-low reset
//   s_tdata/s_tvalid/s_tlast : per-port slave inputs (port i data at
//                              [i*DATA_WIDTH +: DATA_WIDTH])
//   s_tready                 : per-port ready, one-hot or zero
//   m_tdata/m_tvalid/m_tlast : registered master outputs
//   m_tid                    : registered source port of the m beat
//   m_tready                 : downstream ready
module axis_rr_arbiter
  import axis_rr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PORTS      = 4,
  parameter int PORT_BITS  = 2
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic [PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [PORTS-1:0]            s_tvalid,
  input  logic [PORTS-1:0]            s_tlast,
  output logic [PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]       m_tdata,
  output logic                        m_tvalid,
  output logic                        m_tlast,
  output logic [PORT_BITS-1:0]        m_tid,
  input  logic                        m_tready
);

  arb_state_e             state_q, state_d;
  logic [PORT_BITS-1:0]   grant_q, grant_d;
  logic [PORT_BITS-1:0]   last_q, last_d;
  logic                   found;
  logic [PORT_BITS-1:0]   sel;

  logic [DATA_WIDTH-1:0]  gnt_data;
  logic                   gnt_valid;
  logic                   gnt_last;
  logic                   gnt_ready;
  logic                   beat;

  rr_priority_select #(
    .PORTS     (PORTS),
    .PORT_BITS (PORT_BITS)
  ) u_sel (
    .req   (s_tvalid),
    .last  (last_q),
    .found (found),
    .sel   (sel)
  );

  // Output register can take a beat when empty or draining this cycle.
  assign gnt_ready = (state_q == ARB_BUSY) && (!m_tvalid || m_tready);

  // Granted-port mux; compare-based so no variable index into the buses.
  always_comb begin
    gnt_data  = '0;
    gnt_valid = 1'b0;
    gnt_last  = 1'b0;
    for (int i = 0; i < PORTS; i++) begin
      if (grant_q == PORT_BITS'(i)) begin
        gnt_data  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        gnt_valid = s_tvalid[i];
        gnt_last  = s_tlast[i];
      end
    end
  end

  for (genvar i = 0; i < PORTS; i++) begin : g_rdy
    assign s_tready[i] = gnt_ready && (grant_q == PORT_BITS'(i));
  end

  assign beat = gnt_valid && gnt_ready;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    case (state_q)
      ARB_IDLE: begin
        // Pointer moves only on a grant, giving per-packet fairness.
        if (found) begin
          grant_d = sel;
          last_d  = sel;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // No timeout: a stalled granted port keeps the grant.
        if (beat && gnt_last) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= PORT_BITS'(PORTS-1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tid    <= '0;
    end else if (beat) begin
      m_tvalid <= 1'b1;
      m_tdata  <= gnt_data;
      m_tlast  <= gnt_last;
      m_tid    <= grant_q;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
module tb_axis_rr_arbiter;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;

  // 4-port instance
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tvalid = '0;
  logic [3:0]  s_tlast = '0;
  logic [3:0]  s_tready;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tlast;
  logic [1:0]  m_tid;
  logic        m_tready = 1'b1;

  // 3-port instance
  logic [23:0] c_tdata = '0;
  logic [2:0]  c_tvalid = '0;
  logic [2:0]  c_tlast = '0;
  logic [2:0]  c_tready;
  logic [7:0]  c_mdata;
  logic        c_mvalid;
  logic        c_mlast;
  logic [1:0]  c_tid;

  int tests = 0;
  int fails = 0;

  axis_rr_arbiter #(.DATA_WIDTH(8), .PORTS(4), .PORT_BITS(2)) dut (
    .clock(clock), .resetn(resetn),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid),
    .m_tready(m_tready)
  );

  axis_rr_arbiter #(.DATA_WIDTH(8), .PORTS(3), .PORT_BITS(2)) dut3 (
    .clock(clock), .resetn(resetn),
    .s_tdata(c_tdata), .s_tvalid(c_tvalid), .s_tlast(c_tlast), .s_tready(c_tready),
    .m_tdata(c_mdata), .m_tvalid(c_mvalid), .m_tlast(c_mlast), .m_tid(c_tid),
    .m_tready(1'b1)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int p, input logic [7:0] v);
    s_tdata[p*8 +: 8] = v;
  endtask

  initial begin
    // ---- reset state
    #12;
    chk("rst_mvalid", m_tvalid, 0);
    chk("rst_mdata",  m_tdata, 0);
    chk("rst_mlast",  m_tlast, 0);
    chk("rst_mtid",   m_tid, 0);
    chk("rst_sready", s_tready, 0);
    resetn = 1'b1;
    tick();

    // ---- all ports, single-beat packets: tid 0,1,2,3,0 with bubbles
    for (int p = 0; p < 4; p++) put(p, 8'h10 + 8'(p));
    s_tlast  = 4'b1111;
    s_tvalid = 4'b1111;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t1_onehot", 32'($onehot0(s_tready)), 1);
      if (k % 2 == 0) begin
        chk("t1_vld",  m_tvalid, 1);
        chk("t1_tid",  m_tid, (k/2 - 1) % 4);
        chk("t1_data", m_tdata, 8'h10 + (k/2 - 1) % 4);
      end else begin
        chk("t1_bubble", m_tvalid, 0);
      end
    end
    s_tvalid = '0;
    tick();                       // last = 0, idle

    // ---- port 2 three-beat packet, port 0 requests meanwhile
    put(2, 8'hA1); s_tlast = 4'b0001; s_tvalid = 4'b0100;
    tick();                       // grant 2
    chk("t2_rdy", s_tready, 4'b0100);
    put(0, 8'h55); s_tvalid = 4'b0101;
    tick();
    chk("t2_a1",  m_tdata, 8'hA1);
    chk("t2_id1", m_tid, 2);
    chk("t2_l1",  m_tlast, 0);
    chk("t2_rdy2", s_tready, 4'b0100);
    put(2, 8'hA2);
    tick();
    chk("t2_a2",  m_tdata, 8'hA2);
    chk("t2_id2", m_tid, 2);
    put(2, 8'hA3); s_tlast = 4'b0101;
    tick();
    chk("t2_a3",  m_tdata, 8'hA3);
    chk("t2_id3", m_tid, 2);
    chk("t2_l3",  m_tlast, 1);
    s_tvalid = 4'b0001;
    tick();                       // grant 0
    chk("t2_bub", m_tvalid, 0);
    chk("t2_rdy0", s_tready, 4'b0001);
    tick();
    chk("t2_p0v",  m_tvalid, 1);
    chk("t2_p0id", m_tid, 0);
    chk("t2_p0d",  m_tdata, 8'h55);
    s_tvalid = '0;

    // ---- backpressure on a 4-beat packet from port 1
    put(1, 8'hB0); s_tlast = 4'b0000; s_tvalid = 4'b0010;
    tick();                       // grant 1
    tick();
    chk("t3_b0", m_tdata, 8'hB0);
    chk("t3_v0", m_tvalid, 1);
    put(1, 8'hB1); m_tready = 1'b0;
    #1 chk("t3_stall_rdy", s_tready, 0);
    tick();
    chk("t3_hold_d1", m_tdata, 8'hB0);
    chk("t3_hold_v1", m_tvalid, 1);
    chk("t3_hold_i1", m_tid, 1);
    tick();
    chk("t3_hold_d2", m_tdata, 8'hB0);
    chk("t3_hold_l2", m_tlast, 0);
    m_tready = 1'b1;
    tick();
    chk("t3_b1", m_tdata, 8'hB1);
    put(1, 8'hB2);
    tick();
    chk("t3_b2", m_tdata, 8'hB2);
    put(1, 8'hB3); s_tlast = 4'b0010;
    tick();
    chk("t3_b3", m_tdata, 8'hB3);
    chk("t3_l3", m_tlast, 1);
    chk("t3_id", m_tid, 1);
    s_tvalid = '0;
    tick();                       // last = 1, idle

    // ---- granted port 1 stalls for 5 cycles, port 3 waits
    put(1, 8'hC0); put(3, 8'h33); s_tlast = 4'b1000; s_tvalid = 4'b0010;
    tick();                       // grant 1
    tick();
    chk("t4_c0", m_tdata, 8'hC0);
    s_tvalid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t4_stall_v",   m_tvalid, 0);
      chk("t4_stall_rdy", s_tready, 4'b0010);
    end
    put(1, 8'hC1); s_tlast = 4'b1010; s_tvalid = 4'b1010;
    tick();
    chk("t4_c1",  m_tdata, 8'hC1);
    chk("t4_id",  m_tid, 1);
    chk("t4_l",   m_tlast, 1);
    s_tvalid = 4'b1000;
    tick();                       // grant 3
    tick();
    chk("t4_p3id", m_tid, 3);
    chk("t4_p3d",  m_tdata, 8'h33);
    s_tvalid = '0;

    // ---- async reset mid-packet
    put(2, 8'hD0); s_tlast = 4'b0000; s_tvalid = 4'b0100;
    tick();                       // grant 2 (search from last=3)
    tick();
    chk("t6_pre_v", m_tvalid, 1);
    chk("t6_pre_d", m_tdata, 8'hD0);
    #2 resetn = 1'b0;
    #1;
    chk("t6_rst_v",   m_tvalid, 0);
    chk("t6_rst_rdy", s_tready, 0);
    chk("t6_rst_d",   m_tdata, 0);
    for (int p = 0; p < 4; p++) put(p, 8'h10 + 8'(p));
    s_tlast = 4'b1111; s_tvalid = 4'b1111;
    tick();
    chk("t6_held_v", m_tvalid, 0);
    resetn = 1'b1;
    tick();
    chk("t6_gnt0", s_tready, 4'b0001);
    tick();
    chk("t6_v",  m_tvalid, 1);
    chk("t6_id", m_tid, 0);
    chk("t6_d",  m_tdata, 8'h10);
    s_tvalid = '0;

    // ---- PORTS=3 streaming: 0,1,2,0,1,2
    c_tdata = {8'h22, 8'h21, 8'h20};
    c_tlast = 3'b111; c_tvalid = 3'b111;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk("p3_not3", 32'(c_tid == 2'd3), 0);
      chk("p3_onehot", 32'($onehot0(c_tready)), 1);
      if (k % 2 == 0) begin
        chk("p3_vld",  c_mvalid, 1);
        chk("p3_tid",  c_tid, (k/2 - 1) % 3);
        chk("p3_data", c_mdata, 8'h20 + (k/2 - 1) % 3);
      end else begin
        chk("p3_bubble", c_mvalid, 0);
      end
    end
    c_tvalid = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
